// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle between a requester and serial_subtractor.
// The ovf signal exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtract cell plus borrow FF.
// Optional macro SERSUB_OVF_EN adds the two's-complement overflow output ovf.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures a/b.
// busy is high exactly in SHIFT; done is a one-cycle pulse that coincides with
// the first cycle diff/borrow_out (and ovf) hold the new result. Starts while
// busy or in DONE are dropped.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   s_bus,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_shift;
  logic             w_finish;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bo;

  // Full-subtract cell: two half-subtractors chained through the borrow FF.
  assign w_a0 = r_sa[0];
  assign w_b0 = r_sb[0];
  assign w_d  = w_a0 ^ w_b0 ^ r_borrow;
  assign w_bo = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_bus.start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_finish = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_sa     <= s_bus.a;
        r_sb     <= s_bus.b;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
      end
      if (w_shift) begin
        r_res    <= {w_d, r_res[WIDTH-1:1]};
        r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
        r_borrow <= w_bo;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        r_diff       <= r_res;
        r_borrow_out <= r_borrow;
      end
    end
  end

`ifdef SERSUB_OVF_EN
  // Operand MSBs are kept separately because r_sa/r_sb are shifted away.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_msb <= s_bus.a[WIDTH-1];
        r_b_msb <= s_bus.b[WIDTH-1];
      end
      if (w_finish) r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
    end
  end

  assign s_bus.ovf = r_ovf;
`endif

  assign s_bus.busy       = (r_state == S_SHIFT);
  assign s_bus.done       = r_done;
  assign s_bus.diff       = r_diff;
  assign s_bus.borrow_out = r_borrow_out;
  assign o_dbg_state      = r_state;

endmodule
